// File: rtl/inst_rom_arbiter.sv
// Arbiter sharing one combinational-read instruction ROM between the IF fetch
// port and the MEM-stage code-space load port. The MEM port wins conflicts,
// but a wait counter bounds how long IF can starve. Read data is returned
// registered, one cycle after the grant.
module inst_rom_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  output logic              stallreq
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       at_limit;
  logic       conflict;

  // Grant selection, ROM drive and stall request; grants are gated by reset.
  always_comb begin
    at_limit = (wait_cnt == WAIT_LIMIT);
    conflict = if_req & dm_req;
    if_gnt   = rst & if_req & (~dm_req | at_limit);
    dm_gnt   = rst & dm_req & ~(if_req & at_limit);
    rom_ce   = if_gnt | dm_gnt;
    rom_addr = '0;
    if (if_gnt) begin
      rom_addr = if_addr;
    end else if (dm_gnt) begin
      rom_addr = dm_addr;
    end
    stallreq = (if_req & ~if_gnt) | (dm_req & ~dm_gnt);
  end

  // Count consecutive conflicts lost by IF; an IF grant resets the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (conflict && dm_gnt) begin
      if (wait_cnt < WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else if (if_gnt) begin
      wait_cnt <= '0;
    end
  end

  // IF response: data captured on grant, valid suppressed by a same-cycle flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt & ~if_flush;
      if (if_gnt) begin
        if_rdata <= rom_inst;
      end
    end
  end

  // MEM response: one-cycle valid pulse per grant, data held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      dm_rvalid <= dm_gnt;
      if (dm_gnt) begin
        dm_rdata <= rom_inst;
      end
    end
  end

endmodule
